// File: rtl/aes_buf_pkg.sv
// aes_buf_pkg: shared types and constants for the AES block queue.
// Imported by the queue top and its storage sub-module.
package aes_buf_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } aes_buf_state_t;

    // Default-width entry; modules derive their own from TEXT_W/KEY_W
    typedef struct packed {
        logic [AES_BLK_W-1:0] text;
        logic [AES_BLK_W-1:0] key;
    } aes_buf_entry_t;

endpackage

// File: rtl/aes_block_queue_if.sv
// aes_block_queue_if: host load side and cipher-core side of the queue.
// Master drives host/core inputs, slave is the queue itself.
interface aes_block_queue_if #(
    parameter int DEPTH  = 4,
    parameter int TEXT_W = 128,
    parameter int KEY_W  = 128
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              ld_i;
    logic [TEXT_W-1:0] text_in;
    logic [KEY_W-1:0]  key_in;
    logic              flush_i;
    logic              clr_ovf_i;
    logic              done_i;
    logic              ready_o;
    logic [TEXT_W-1:0] text_o;
    logic [KEY_W-1:0]  key_o;
    logic              ld_o;
    logic              busy_o;
    logic [CW-1:0]     count_o;
    logic              ovf_o;

    modport master (
        output ld_i, text_in, key_in, flush_i, clr_ovf_i, done_i,
        input  ready_o, text_o, key_o, ld_o, busy_o, count_o, ovf_o
    );

    modport slave (
        input  ld_i, text_in, key_in, flush_i, clr_ovf_i, done_i,
        output ready_o, text_o, key_o, ld_o, busy_o, count_o, ovf_o
    );

endinterface

// File: rtl/aes_buf_fifo.sv
// aes_buf_fifo: circular store of queued blocks with explicit pointer wrap,
// so DEPTH need not be a power of two. Flush drops everything unissued.
module aes_buf_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 256,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        return p + PW'(1);
    endfunction

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rd];

    // Full is registered: a same-cycle pop never makes room for a push
    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= r_wr;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wr <= f_nxt(r_wr);
            if (w_pop)
                r_rd <= f_nxt(r_rd);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/aes_block_queue.sv
// aes_block_queue: queues host plaintext/key pairs and issues them one at a
// time to the cipher core, waiting for done between blocks.
module aes_block_queue
    import aes_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TEXT_W = AES_BLK_W,
    parameter int KEY_W  = AES_BLK_W
) (
    input  logic              clk,
    input  logic              rst,
    aes_block_queue_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TEXT_W-1:0] text;
        logic [KEY_W-1:0]  key;
    } entry_t;

    localparam int ENT_W = $bits(entry_t);

    aes_buf_state_t    r_state;
    aes_buf_state_t    w_state_nxt;
    logic [TEXT_W-1:0] r_text;
    logic [KEY_W-1:0]  r_key;
    logic              r_ovf;
    entry_t            w_head;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_avail;
    logic              w_pop;

    aes_buf_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.ld_i),
        .i_pop   (w_pop),
        .i_flush (bus.flush_i),
        .i_din   ({bus.text_in, bus.key_in}),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A flush in the same cycle hides the queued entries from the issue logic
    assign w_avail = !w_empty && !bus.flush_i;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_avail) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = BUSY;
            BUSY: begin
                if (bus.done_i) begin
                    if (w_avail) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_text  <= '0;
            r_key   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_text <= w_head.text;
                r_key  <= w_head.key;
            end
            if (bus.ld_i && w_full && !bus.flush_i)
                r_ovf <= 1'b1;
            else if (bus.clr_ovf_i)
                r_ovf <= 1'b0;
        end
    end

    assign bus.ready_o = !w_full;
    assign bus.count_o = w_count;
    assign bus.ld_o    = (r_state == ISSUE);
    assign bus.busy_o  = (r_state != IDLE);
    assign bus.text_o  = r_text;
    assign bus.key_o   = r_key;
    assign bus.ovf_o   = r_ovf;

endmodule

// File: tb/tb_aes_block_queue.sv
// tb_aes_block_queue: scoreboard bench for a DEPTH=4 queue and a DEPTH=3
// queue (wrap-around); issued blocks are popped and compared in order.
module tb_aes_block_queue;

    typedef struct packed {
        logic [127:0] t;
        logic [127:0] k;
    } blk_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_block_queue_if #(.DEPTH(4)) a ();
    aes_block_queue_if #(.DEPTH(3)) b ();

    aes_block_queue #(.DEPTH(4)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    aes_block_queue #(.DEPTH(3)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    blk_t qa[$];
    blk_t qb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lda_n  = 0;
    int   ldb_n  = 0;
    logic la_prev = 1'b0;
    logic lb_prev = 1'b0;

    task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic blk_t rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(blk_t v, bit acc);
        a.ld_i    = 1'b1;
        a.text_in = v.t;
        a.key_in  = v.k;
        if (acc) qa.push_back(v);
        step();
        a.ld_i = 1'b0;
    endtask

    task automatic push_b(blk_t v);
        b.ld_i    = 1'b1;
        b.text_in = v.t;
        b.key_in  = v.k;
        qb.push_back(v);
        step();
        b.ld_i = 1'b0;
    endtask

    task automatic done_a(bit exp_ld);
        a.done_i = 1'b1;
        step();
        a.done_i = 1'b0;
        chk("a_ld_after_done", a.ld_o, exp_ld);
    endtask

    task automatic done_b(bit exp_ld);
        b.done_i = 1'b1;
        step();
        b.done_i = 1'b0;
        chk("b_ld_after_done", b.ld_o, exp_ld);
    endtask

    always @(negedge clk) begin
        if (!rst && a.ld_o) begin
            blk_t e;
            lda_n++;
            chk("a_ld_consec", la_prev, 0);
            chk("a_pending", qa.size() > 0, 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_text", a.text_o, e.t);
                chk("a_key", a.key_o, e.k);
            end
        end
        la_prev = a.ld_o;
    end

    always @(negedge clk) begin
        if (!rst && b.ld_o) begin
            blk_t e;
            ldb_n++;
            chk("b_ld_consec", lb_prev, 0);
            chk("b_pending", qb.size() > 0, 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_text", b.text_o, e.t);
                chk("b_key", b.key_o, e.k);
            end
        end
        lb_prev = b.ld_o;
    end

    initial begin
        blk_t v0;
        int   grp [4] = '{3, 3, 3, 1};
        a.ld_i = 0; a.text_in = '0; a.key_in = '0;
        a.flush_i = 0; a.clr_ovf_i = 0; a.done_i = 0;
        b.ld_i = 0; b.text_in = '0; b.key_in = '0;
        b.flush_i = 0; b.clr_ovf_i = 0; b.done_i = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        chk("rst_count", a.count_o, 0);
        chk("rst_ready", a.ready_o, 1);
        chk("rst_ld", a.ld_o, 0);
        chk("rst_busy", a.busy_o, 0);
        chk("rst_ovf", a.ovf_o, 0);
        chk("rst_text", a.text_o, 0);
        chk("rst_key", a.key_o, 0);

        // single block latency
        v0.t = 128'h00112233_44556677_8899aabb_ccddeeff;
        v0.k = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        push_a(v0, 1);
        chk("s_count_k1", a.count_o, 1);
        chk("s_ld_k1", a.ld_o, 0);
        step();
        chk("s_ld_k2", a.ld_o, 1);
        chk("s_text_k2", a.text_o, v0.t);
        chk("s_key_k2", a.key_o, v0.k);
        chk("s_count_k2", a.count_o, 0);
        chk("s_busy_k2", a.busy_o, 1);
        step(5);
        chk("s_busy_wait", a.busy_o, 1);
        done_a(0);
        chk("s_idle", a.busy_o, 0);
        chk("s_ld_n", lda_n, 1);

        // burst fill and overflow
        repeat (5) push_a(rnd(), 1);
        chk("b_count4", a.count_o, 4);
        chk("b_ready0", a.ready_o, 0);
        chk("b_ovf0", a.ovf_o, 0);
        chk("b_ld_n", lda_n, 2);
        push_a(rnd(), 0);
        chk("b_ovf1", a.ovf_o, 1);
        chk("b_count_keep", a.count_o, 4);
        a.clr_ovf_i = 1'b1;
        push_a(rnd(), 0);
        a.clr_ovf_i = 1'b0;
        chk("b_ovf_setwins", a.ovf_o, 1);
        a.clr_ovf_i = 1'b1;
        step();
        a.clr_ovf_i = 1'b0;
        chk("b_ovf_clr", a.ovf_o, 0);

        // back-to-back drain, done every 12 cycles
        repeat (4) begin
            done_a(1);
            step(11);
        end
        done_a(0);
        step(4);
        chk("d_idle", a.busy_o, 0);
        chk("d_ld_n", lda_n, 6);
        chk("d_q_empty", qa.size(), 0);

        // flush while busy
        push_a(rnd(), 1);
        repeat (3) push_a(rnd(), 0);
        chk("f_count3", a.count_o, 3);
        a.flush_i = 1'b1;
        step();
        a.flush_i = 1'b0;
        chk("f_count0", a.count_o, 0);
        chk("f_busy", a.busy_o, 1);
        done_a(0);
        step(5);
        chk("f_idle", a.busy_o, 0);
        chk("f_ld_n", lda_n, 7);
        chk("f_ready", a.ready_o, 1);

        // flush beats push
        a.flush_i = 1'b1;
        push_a(rnd(), 0);
        a.flush_i = 1'b0;
        chk("fp_count", a.count_o, 0);
        chk("fp_ovf", a.ovf_o, 0);
        step(3);
        chk("fp_ld_n", lda_n, 7);
        chk("fp_busy", a.busy_o, 0);

        // wrap-around on DEPTH=3
        foreach (grp[g]) begin
            repeat (grp[g]) push_b(rnd());
            for (int j = 0; j < grp[g]; j++) begin
                step(2);
                done_b(j < grp[g] - 1);
            end
        end
        step(3);
        chk("w_ld_n", ldb_n, 10);
        chk("w_q_empty", qb.size(), 0);
        chk("w_idle", b.busy_o, 0);

        // async reset mid-BUSY with two queued
        push_a(rnd(), 1);
        push_a(rnd(), 0);
        push_a(rnd(), 0);
        chk("r_count2", a.count_o, 2);
        chk("r_busy1", a.busy_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("r_async_count", a.count_o, 0);
        chk("r_async_busy", a.busy_o, 0);
        chk("r_async_ready", a.ready_o, 1);
        chk("r_async_ld", a.ld_o, 0);
        chk("r_async_text", a.text_o, 0);
        chk("r_async_key", a.key_o, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        done_a(0);
        step(4);
        chk("r_ld_n", lda_n, 8);
        chk("r_idle", a.busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
